// File: rtl/mem_req_arbiter.sv
// Registered i/d memory request arbiter with a one-entry posted write buffer.
// Reads that alias the buffered store wait until that store has drained.
module mem_req_arbiter #(
   parameter int WB_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   input  logic        i_strobe,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic [31:0] d_addr,
   input  logic        d_strobe,
   input  logic        d_rw,
   input  logic [1:0]  d_size,
   input  logic [3:0]  d_wen,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic [31:0] mem_a,
   output logic        mem_access,
   output logic        mem_write,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_st_data,
   input  logic [31:0] mem_data,
   input  logic        mem_ready
);

   localparam logic POSTED = (WB_EN != 0);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      I_RD     = 3'd1,
      D_RD     = 3'd2,
      WB_DRAIN = 3'd3,
      D_WR     = 3'd4
   } state_t;

   state_t      state;

   logic        wb_valid;
   logic [31:0] wb_addr;
   logic [1:0]  wb_size;
   logic [3:0]  wb_wen;
   logic [31:0] wb_data;

   logic        d_rd_req;
   logic        d_wr_req;
   logic        d_alias;
   logic        i_alias;
   logic        alias_hit;
   logic        drain_done;
   logic        wb_accept;

   assign d_rd_req   = d_strobe & ~d_rw;
   assign d_wr_req   = d_strobe & d_rw;
   assign d_alias    = d_rd_req & (d_addr[31:2] == wb_addr[31:2]);
   assign i_alias    = i_strobe & (i_addr[31:2] == wb_addr[31:2]);
   assign alias_hit  = wb_valid & (d_alias | i_alias);
   assign drain_done = (state == WB_DRAIN) & mem_ready;

   // A store is taken whenever the buffer is empty or is retiring this cycle
   assign wb_accept = POSTED & d_wr_req & (~wb_valid | drain_done);

   // Completion pulses follow the bridge; read data is a straight passthrough
   always_comb begin
      i_rdata = mem_data;
      d_rdata = mem_data;
      i_ready = ~rst & (state == I_RD) & mem_ready;
      d_ready = ~rst & (((state == D_RD) & mem_ready) |
                        ((state == D_WR) & mem_ready) |
                        wb_accept);
   end

   // Posted write buffer: capture on accept, retire when the drain completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_size  <= '0;
         wb_wen   <= '0;
         wb_data  <= '0;
      end else if (wb_accept) begin
         wb_valid <= 1'b1;
         wb_addr  <= d_addr;
         wb_size  <= d_size;
         wb_wen   <= d_wen;
         wb_data  <= d_wdata;
      end else if (drain_done) begin
         wb_valid <= 1'b0;
      end
   end

   // Arbiter FSM: registered request loaded on grant, held until mem_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem_a       <= '0;
         mem_access  <= 1'b0;
         mem_write   <= 1'b0;
         mem_size    <= '0;
         mem_sel     <= '0;
         mem_st_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (alias_hit) begin
                  state       <= WB_DRAIN;
                  mem_a       <= wb_addr;
                  mem_size    <= wb_size;
                  mem_sel     <= wb_wen;
                  mem_st_data <= wb_data;
                  mem_write   <= 1'b1;
                  mem_access  <= 1'b1;
               end else if (d_rd_req) begin
                  state      <= D_RD;
                  mem_a      <= d_addr;
                  mem_size   <= d_size;
                  mem_sel    <= d_wen;
                  mem_write  <= 1'b0;
                  mem_access <= 1'b1;
               end else if (!POSTED && d_wr_req) begin
                  state       <= D_WR;
                  mem_a       <= d_addr;
                  mem_size    <= d_size;
                  mem_sel     <= d_wen;
                  mem_st_data <= d_wdata;
                  mem_write   <= 1'b1;
                  mem_access  <= 1'b1;
               end else if (i_strobe) begin
                  state      <= I_RD;
                  mem_a      <= i_addr;
                  mem_size   <= 2'b10;
                  mem_sel    <= 4'b1111;
                  mem_write  <= 1'b0;
                  mem_access <= 1'b1;
               end else if (wb_valid) begin
                  state       <= WB_DRAIN;
                  mem_a       <= wb_addr;
                  mem_size    <= wb_size;
                  mem_sel     <= wb_wen;
                  mem_st_data <= wb_data;
                  mem_write   <= 1'b1;
                  mem_access  <= 1'b1;
               end
            end
            default: begin
               if (mem_ready) begin
                  state      <= IDLE;
                  mem_access <= 1'b0;
                  mem_write  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: fetch, data priority, posted stores,
// alias hold, full-buffer stall and asynchronous reset.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr;
   logic        i_strobe;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic [31:0] d_addr;
   logic        d_strobe;
   logic        d_rw;
   logic [1:0]  d_size;
   logic [3:0]  d_wen;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic [31:0] mem_a;
   logic        mem_access;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic [3:0]  mem_sel;
   logic [31:0] mem_st_data;
   logic [31:0] mem_data;
   logic        mem_ready;

   int n_cmp = 0;
   int n_err = 0;

   mem_req_arbiter #(.WB_EN(1)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_strobe(i_strobe),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_addr(d_addr), .d_strobe(d_strobe), .d_rw(d_rw),
      .d_size(d_size), .d_wen(d_wen), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
      .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
      .mem_data(mem_data), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      i_addr = '0; i_strobe = 1'b0;
      d_addr = '0; d_strobe = 1'b0; d_rw = 1'b0;
      d_size = '0; d_wen = '0; d_wdata = '0;
      mem_data = '0; mem_ready = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_access", 32'(mem_access), 32'd0);
      chk("rst_write", 32'(mem_write), 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_sel", 32'(mem_sel), 32'd0);
      chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk("rst_wbv", 32'(dut.wb_valid), 32'd0);
      rst = 1'b0;

      // 1: single fetch
      tick();
      i_strobe = 1'b1; i_addr = 32'hBFC00000;
      tick();
      chk("t1_access", 32'(mem_access), 32'd1);
      chk("t1_a", mem_a, 32'hBFC00000);
      chk("t1_sel", 32'(mem_sel), 32'hF);
      chk("t1_size", 32'(mem_size), 32'd2);
      chk("t1_write", 32'(mem_write), 32'd0);
      chk("t1_irdy_pre", 32'(i_ready), 32'd0);
      mem_ready = 1'b1; mem_data = 32'h3C08BFAF;
      #1;
      chk("t1_irdy", 32'(i_ready), 32'd1);
      chk("t1_rdata", i_rdata, 32'h3C08BFAF);
      tick();
      i_strobe = 1'b0; mem_ready = 1'b0;
      #1;
      chk("t1_done", {30'd0, mem_access, i_ready}, 32'd0);

      // 2: data read outranks a simultaneous fetch
      d_strobe = 1'b1; d_rw = 1'b0; d_addr = 32'h80001000;
      d_size = 2'b10; d_wen = 4'hF;
      i_strobe = 1'b1; i_addr = 32'hBFC00004;
      tick();
      chk("t2_a_d", mem_a, 32'h80001000);
      chk("t2_rdy0", {30'd0, i_ready, d_ready}, 32'd0);
      mem_ready = 1'b1; mem_data = 32'h11112222;
      #1;
      chk("t2_rdy_d", {30'd0, i_ready, d_ready}, 32'd1);
      chk("t2_drdata", d_rdata, 32'h11112222);
      tick();
      d_strobe = 1'b0; mem_ready = 1'b0;
      #1;
      chk("t2_gap", {30'd0, mem_access, i_ready}, 32'd0);
      tick();
      chk("t2_a_i", mem_a, 32'hBFC00004);
      chk("t2_acc_i", 32'(mem_access), 32'd1);
      mem_ready = 1'b1; mem_data = 32'h33334444;
      #1;
      chk("t2_rdy_i", {30'd0, i_ready, d_ready}, 32'd2);
      chk("t2_irdata", i_rdata, 32'h33334444);
      tick();
      i_strobe = 1'b0; mem_ready = 1'b0;
      #1;

      // 3: posted store completes immediately, drained afterwards
      d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h80002004;
      d_size = 2'b01; d_wen = 4'b0011; d_wdata = 32'h0000BEEF;
      #1;
      chk("t3_accept", 32'(d_ready), 32'd1);
      tick();
      d_strobe = 1'b0;
      #1;
      chk("t3_drdy_off", 32'(d_ready), 32'd0);
      chk("t3_wbv", 32'(dut.wb_valid), 32'd1);
      tick();
      chk("t3_acc", 32'(mem_access), 32'd1);
      chk("t3_write", 32'(mem_write), 32'd1);
      chk("t3_sel", 32'(mem_sel), 32'h3);
      chk("t3_data", mem_st_data, 32'h0000BEEF);
      chk("t3_a", mem_a, 32'h80002004);
      chk("t3_size", 32'(mem_size), 32'd1);
      mem_ready = 1'b1;
      #1;
      chk("t3_no_drdy", 32'(d_ready), 32'd0);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t3_idle", {30'd0, mem_access, dut.wb_valid}, 32'd0);

      // 4: load aliasing the buffered store waits for the drain
      d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h80002004;
      d_size = 2'b10; d_wen = 4'hF; d_wdata = 32'h12345678;
      #1;
      chk("t4_accept", 32'(d_ready), 32'd1);
      tick();
      d_rw = 1'b0; d_addr = 32'h80002006; d_size = 2'b01; d_wen = 4'b1100;
      #1;
      chk("t4_hold", 32'(d_ready), 32'd0);
      tick();
      chk("t4_drain_w", 32'(mem_write), 32'd1);
      chk("t4_drain_a", mem_a, 32'h80002004);
      chk("t4_drain_d", mem_st_data, 32'h12345678);
      tick();
      chk("t4_drain_hold", {30'd0, mem_access, mem_write}, 32'd3);
      mem_ready = 1'b1;
      #1;
      chk("t4_ld_wait", 32'(d_ready), 32'd0);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t4_gap", 32'(mem_access), 32'd0);
      tick();
      chk("t4_ld_a", mem_a, 32'h80002006);
      chk("t4_ld_w", 32'(mem_write), 32'd0);
      chk("t4_ld_size", 32'(mem_size), 32'd1);
      mem_ready = 1'b1; mem_data = 32'hCAFE0000;
      #1;
      chk("t4_ld_rdy", 32'(d_ready), 32'd1);
      chk("t4_ld_data", d_rdata, 32'hCAFE0000);
      tick();
      d_strobe = 1'b0; mem_ready = 1'b0;
      #1;

      // 5: second store stalls until the drain completes, then same-cycle swap
      d_strobe = 1'b1; d_rw = 1'b1; d_addr = 32'h80003000;
      d_size = 2'b10; d_wen = 4'hF; d_wdata = 32'hAAAA0001;
      #1;
      chk("t5_accA", 32'(d_ready), 32'd1);
      tick();
      d_addr = 32'h80003004; d_wdata = 32'hBBBB0002;
      #1;
      chk("t5_stall0", 32'(d_ready), 32'd0);
      tick();
      chk("t5_drainA", mem_a, 32'h80003000);
      chk("t5_stall1", 32'(d_ready), 32'd0);
      tick();
      chk("t5_stall2", {30'd0, mem_access, d_ready}, 32'd2);
      mem_ready = 1'b1;
      #1;
      chk("t5_accB", 32'(d_ready), 32'd1);
      tick();
      d_strobe = 1'b0; mem_ready = 1'b0;
      #1;
      chk("t5_wbv_kept", 32'(dut.wb_valid), 32'd1);
      chk("t5_wb_addr", dut.wb_addr, 32'h80003004);
      tick();
      chk("t5_drainB_a", mem_a, 32'h80003004);
      chk("t5_drainB_d", mem_st_data, 32'hBBBB0002);
      mem_ready = 1'b1;
      #1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t5_empty", {30'd0, mem_access, dut.wb_valid}, 32'd0);

      // 6: asynchronous reset during a fetch
      i_strobe = 1'b1; i_addr = 32'h00400000;
      tick();
      chk("t6_acc", 32'(mem_access), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_acc_rst", 32'(mem_access), 32'd0);
      chk("t6_state", 32'(dut.state), 32'd0);
      i_strobe = 1'b0;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1; mem_data = 32'hDEADBEEF;
      #1;
      chk("t6_no_irdy", {30'd0, i_ready, d_ready}, 32'd0);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t6_idle", 32'(mem_access), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the instruction/data cache memory ports and the AXI bridge's single cache-side request port.
- Replaces the combinational i/d select with a registered arbiter.
- Adds a one-entry posted write buffer, so data-cache stores complete without waiting for the AXI write response.
- Reads that alias a buffered write are held until that write has drained.

Parameters:
- WB_EN, 1: 1 = stores are posted into the write buffer; 0 = stores are forwarded unbuffered, and d_ready is returned on mem_ready.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_addr  in  32  icache fetch address
- i_strobe  in  1  icache request; held until i_ready
- i_rdata  out  32  fetch data (mem_data passthrough)
- i_ready  out  1  one-cycle completion pulse
- d_addr  in  32  dcache address
- d_strobe  in  1  dcache request; held until d_ready
- d_rw  in  1  0 = read, 1 = write
- d_size  in  2  00 byte, 01 half, 10 word
- d_wen  in  4  byte strobes
- d_wdata  in  32  store data
- d_rdata  out  32  load data (mem_data passthrough)
- d_ready  out  1  one-cycle completion pulse
- mem_a  out  32  address to bridge
- mem_access  out  1  request valid; held until mem_ready
- mem_write  out  1  1 = write
- mem_size  out  2  transfer size
- mem_sel  out  4  byte strobes
- mem_st_data  out  32  write data
- mem_data  in  32  read data from bridge
- mem_ready  in  1  one-cycle completion pulse from bridge

Behaviour:
- Reset (async, rst=1): state=IDLE, wb_valid=0; mem_access, mem_write, i_ready and d_ready are 0; mem_a, mem_size, mem_sel and mem_st_data are 0.
- Reset mid-transaction abandons it; the bridge is reset by the same rst.
- States: IDLE, I_RD, D_RD, WB_DRAIN, D_WR (D_WR is used only when WB_EN=0).
- Request outputs are registered; they are loaded on the IDLE→owner transition and held constant until mem_ready.
- Owner state → mem port contents:
  - I_RD: mem_a=i_addr, size=10, sel=1111, write=0.
  - D_RD: d_addr, d_size, d_wen, write=0.
  - WB_DRAIN: buffered addr/size/wen/data, write=1.
- Alias check: req_addr[31:2] == wb_addr[31:2] with wb_valid=1.
- IDLE priority, first match wins:
  1. wb_valid and an aliasing pending read (d or i) → WB_DRAIN.
  2. d_strobe & ~d_rw → D_RD.
  3. i_strobe → I_RD.
  4. wb_valid → WB_DRAIN.
  5. Otherwise stay in IDLE.
- The data side outranks fetch because the MEM-stage instruction is older.
- Any owner state returns to IDLE on mem_ready.
  - In I_RD: i_ready=mem_ready, combinational, with i_rdata=mem_data.
  - In D_RD: d_ready=mem_ready with d_rdata=mem_data.
- Read latency: strobe seen in IDLE at cycle N → mem_access=1 at N+1 → ready in the same cycle as mem_ready.
- Posted write (WB_EN=1):
  - accept = d_strobe & d_rw & (~wb_valid | (state==WB_DRAIN & mem_ready)).
  - d_ready=accept, combinational; the entry {addr, size, wen, data} is captured on that edge and wb_valid=1.
  - Accept is legal in any state; the buffer is independent of the read FSM.
- Simultaneous drain-complete and new store in the same cycle: the new entry is captured, wb_valid stays 1, the old entry is retired, and no cycle is lost.
- Buffer full (wb_valid=1, not completing) with a new store: d_ready=0 until drain completes.
- Only the store path stalls; reads still arbitrate per the priority above.
- WB_EN=0: a store is treated like a read through state D_WR, with write=1; d_ready=mem_ready.
- i_ready and d_ready never assert in the same cycle, except a posted-write accept coinciding with I_RD completion. That case is legal because the two pulses go to different caches.
- At most one mem transaction is outstanding; mem_access never drops before mem_ready.

Test Plan:
1. After reset, i_strobe with i_addr=0xBFC00000 → mem_access=1 next cycle, mem_a=0xBFC00000, sel=1111, size=10. mem_ready with mem_data=0x3C08BFAF → i_ready pulse, i_rdata=0x3C08BFAF.
2. d_strobe read 0x80001000 and i_strobe 0xBFC00004 raised in the same cycle → D_RD is served first, then I_RD. Exactly one d_ready and one i_ready pulse, in that order.
3. Store to 0x80002004, wen=0011, data=0x0000BEEF → d_ready in the same cycle. The WB_DRAIN request then carries mem_write=1, sel=0011, st_data=0x0000BEEF.
4. Buffered store to 0x80002004, then a load from 0x80002006 while the buffer is still pending → the drain goes out first, and the load's mem_access follows only after the drain's mem_ready.
5. Second store presented while the drain is pending → d_ready=0 until the drain's mem_ready. The store is accepted in that same cycle, and wb_valid never drops.
6. Assert rst during I_RD with mem_access=1 → mem_access=0 and state=IDLE immediately (asynchronously). A later mem_ready produces no i_ready pulse.
